// File: rtl/ov_cam_pkg.sv
// ============================================================================
//  Module      : ov_cam_pkg
//  Description : Shared defaults, reader state encodings, trailer bytes and a
//                width helper for the OV7670/AL422B frame FIFO reader.
//                The TRAILER state exists only when OV_FIFO_READER_TRAILER_EN
//                is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ov_cam_pkg;

    // Frame geometry defaults for a QVGA RGB565/YUV422 capture
    localparam int H_RES_DEFAULT = 320;
    localparam int V_RES_DEFAULT = 240;
    localparam int BPP_DEFAULT   = 2;

    // Bytes appended after the window stream when the trailer is enabled
    localparam logic [7:0] TRAILER_CR = 8'h0D;
    localparam logic [7:0] TRAILER_LF = 8'h0A;

    // Reader sequencer states
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_PTR_RST   = 4'd1,
        ST_PTR_REL   = 4'd2,
        ST_RD_LO     = 4'd3,
        ST_RD_SAMPLE = 4'd4,
        ST_EMIT      = 4'd5,
        ST_RD_HI     = 4'd6,
`ifdef OV_FIFO_READER_TRAILER_EN
        ST_TRAILER   = 4'd7,
`endif
        ST_DONE      = 4'd8
    } rd_state_t;

    // Bits needed to hold 0..n-1, never less than one bit
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ov_rclk_timer.sv
// ============================================================================
//  Module      : ov_rclk_timer
//  Description : Half-period down-counter for the FIFO read clock. Loading
//                value N makes o_done assert after N further cycles, so a
//                state that loads N-1 on entry lasts exactly N cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ov_rclk_timer
    import ov_cam_pkg::*;
#(
    parameter int RCLK_DIV = 1,
    parameter int WIDTH    = clog2_min1(RCLK_DIV)
) (
    input  logic             clk_25MHz,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_done
);

    if (RCLK_DIV < 1) begin : g_bad_div
        $error("ov_rclk_timer: RCLK_DIV must be at least 1");
    end

    logic [WIDTH-1:0] r_cnt;

    // Count down to zero and park there; a load always wins
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/ov_fifo_window_reader.sv
// ============================================================================
//  Module      : ov_fifo_window_reader
//  Description : Reads one complete frame out of the AL422B FIFO per
//                new_frame, resetting the read pointer first, and forwards
//                only the bytes inside a rectangular crop window as a
//                ready/valid byte stream. The sink's ready stalls the FIFO
//                read clock, so no byte is ever lost or clocked out early.
//                Define OV_FIFO_READER_TRAILER_EN to append CR/LF after the
//                frame; m_last then marks the LF instead of the last pixel.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ov_fifo_window_reader
    import ov_cam_pkg::*;
#(
    parameter int H_RES    = H_RES_DEFAULT,
    parameter int V_RES    = V_RES_DEFAULT,
    parameter int BPP      = BPP_DEFAULT,
    parameter int X0       = 0,
    parameter int Y0       = 0,
    parameter int WIN_W    = 320,
    parameter int WIN_H    = 240,
    parameter int RCLK_DIV = 1
) (
    input  logic       clk_25MHz,
    input  logic       rst_n,
    input  logic       initialized,
    input  logic       new_frame,
    input  logic [7:0] fifo_data,
    output logic       rclk,
    output logic       rrst,
    output logic       frame_read,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] m_data,
    output logic       m_last
);

    // ------------------------------------------------------------------
    // Geometry checks
    // ------------------------------------------------------------------
    if (X0 + WIN_W > H_RES) begin : g_bad_win_x
        $error("ov_fifo_window_reader: X0+WIN_W exceeds H_RES");
    end
    if (Y0 + WIN_H > V_RES) begin : g_bad_win_y
        $error("ov_fifo_window_reader: Y0+WIN_H exceeds V_RES");
    end
    if (RCLK_DIV < 1) begin : g_bad_div
        $error("ov_fifo_window_reader: RCLK_DIV must be at least 1");
    end

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int c_col_w  = clog2_min1(H_RES * BPP);
    localparam int c_line_w = clog2_min1(V_RES);
    localparam int c_tmr_w  = clog2_min1(RCLK_DIV);

    localparam logic [c_col_w-1:0]  c_col_last      = c_col_w'(H_RES * BPP - 1);
    localparam logic [c_line_w-1:0] c_line_last     = c_line_w'(V_RES - 1);
    localparam logic [c_col_w-1:0]  c_win_col_last  = c_col_w'((X0 + WIN_W) * BPP - 1);
    localparam logic [c_line_w-1:0] c_win_line_last = c_line_w'(Y0 + WIN_H - 1);

    localparam int unsigned c_win_col0 = X0 * BPP;
    localparam int unsigned c_win_cols = WIN_W * BPP;
    localparam int unsigned c_win_row0 = Y0;
    localparam int unsigned c_win_rows = WIN_H;

    // Full half-period, and the low-phase lead-in that precedes the sample cycle
    localparam logic [c_tmr_w-1:0] c_hold_full = c_tmr_w'(RCLK_DIV - 1);
    localparam logic [c_tmr_w-1:0] c_hold_lo   = c_tmr_w'((RCLK_DIV > 1) ? RCLK_DIV - 2 : 0);

    // With a one-cycle half-period the sample cycle is the whole low phase
    localparam rd_state_t c_rd_entry = (RCLK_DIV > 1) ? ST_RD_LO : ST_RD_SAMPLE;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    rd_state_t           r_state;
    logic [c_col_w-1:0]  r_col;
    logic [c_line_w-1:0] r_line;
    logic                r_ptr_pulse;
    logic                r_rclk;
    logic                r_rrst;
    logic                r_frame_read;
    logic                r_m_valid;
    logic [7:0]          r_m_data;
    logic                r_m_last;
`ifdef OV_FIFO_READER_TRAILER_EN
    logic                r_trl_lf;
`endif

    logic                w_start;
    logic                w_hs;
    logic                w_in_win;
    logic                w_last_win;
    logic                w_last_byte;
    logic                w_last_emit;
    logic [31:0]         w_col_ofs;
    logic [31:0]         w_line_ofs;
    logic                w_tmr_load;
    logic [c_tmr_w-1:0]  w_tmr_val;
    logic                w_tmr_done;

    assign w_start = initialized && new_frame;
    assign w_hs    = r_m_valid && m_ready;

    // Offsets wrap to huge values below the window origin, so one unsigned
    // compare per axis covers both window edges
    assign w_col_ofs  = 32'(r_col) - c_win_col0;
    assign w_line_ofs = 32'(r_line) - c_win_row0;
    assign w_in_win   = (w_col_ofs < c_win_cols) && (w_line_ofs < c_win_rows);

    assign w_last_win  = (r_col == c_win_col_last) && (r_line == c_win_line_last);
    assign w_last_byte = (r_col == c_col_last) && (r_line == c_line_last);

`ifdef OV_FIFO_READER_TRAILER_EN
    assign w_last_emit = 1'b0;
`else
    assign w_last_emit = w_last_win;
`endif

    // Reload the half-period timer on every rclk phase change
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = c_hold_full;
        case (r_state)
            ST_IDLE:      w_tmr_load = w_start;
            ST_PTR_RST:   w_tmr_load = w_tmr_done;
            ST_PTR_REL: begin
                w_tmr_load = w_tmr_done;
                w_tmr_val  = c_hold_lo;
            end
            ST_RD_SAMPLE: w_tmr_load = !w_in_win;
            ST_EMIT:      w_tmr_load = w_hs;
            ST_RD_HI: begin
                w_tmr_load = w_tmr_done && !w_last_byte;
                w_tmr_val  = c_hold_lo;
            end
            default:      w_tmr_load = 1'b0;
        endcase
    end

    ov_rclk_timer #(
        .RCLK_DIV (RCLK_DIV),
        .WIDTH    (c_tmr_w)
    ) u_rclk_timer (
        .clk_25MHz  (clk_25MHz),
        .rst_n      (rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_done     (w_tmr_done)
    );

    // Frame sequencer: pointer reset, per-byte read cycle, window forwarding
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_col        <= '0;
            r_line       <= '0;
            r_ptr_pulse  <= 1'b0;
            r_rclk       <= 1'b1;
            r_rrst       <= 1'b1;
            r_frame_read <= 1'b1;
            r_m_valid    <= 1'b0;
            r_m_data     <= 8'h00;
            r_m_last     <= 1'b0;
`ifdef OV_FIFO_READER_TRAILER_EN
            r_trl_lf     <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_frame_read <= 1'b0;
                        r_rrst       <= 1'b0;
                        r_rclk       <= 1'b0;
                        r_col        <= '0;
                        r_line       <= '0;
                        r_ptr_pulse  <= 1'b0;
                        r_state      <= ST_PTR_RST;
                    end
                end

                // Two complete rclk pulses with rrst low
                ST_PTR_RST: begin
                    if (w_tmr_done) begin
                        if (!r_rclk) begin
                            r_rclk <= 1'b1;
                        end else if (r_ptr_pulse) begin
                            r_rrst  <= 1'b1;
                            r_state <= ST_PTR_REL;
                        end else begin
                            r_ptr_pulse <= 1'b1;
                            r_rclk      <= 1'b0;
                        end
                    end
                end

                // Release rrst a full half-period before the first read edge
                ST_PTR_REL: begin
                    if (w_tmr_done) begin
                        r_rclk  <= 1'b0;
                        r_state <= c_rd_entry;
                    end
                end

                ST_RD_LO: begin
                    if (w_tmr_done) begin
                        r_state <= ST_RD_SAMPLE;
                    end
                end

                // Last low cycle: the FIFO output has settled
                ST_RD_SAMPLE: begin
                    if (w_in_win) begin
                        r_m_valid <= 1'b1;
                        r_m_data  <= fifo_data;
                        r_m_last  <= w_last_emit;
                        r_state   <= ST_EMIT;
                    end else begin
                        r_rclk  <= 1'b1;
                        r_state <= ST_RD_HI;
                    end
                end

                // rclk stays low until the sink takes the byte
                ST_EMIT: begin
                    if (w_hs) begin
                        r_m_valid <= 1'b0;
                        r_m_last  <= 1'b0;
                        r_rclk    <= 1'b1;
                        r_state   <= ST_RD_HI;
                    end
                end

                ST_RD_HI: begin
                    if (w_tmr_done) begin
                        if (w_last_byte) begin
`ifdef OV_FIFO_READER_TRAILER_EN
                            r_m_valid <= 1'b1;
                            r_m_data  <= TRAILER_CR;
                            r_m_last  <= 1'b0;
                            r_trl_lf  <= 1'b0;
                            r_state   <= ST_TRAILER;
`else
                            r_state   <= ST_DONE;
`endif
                        end else begin
                            if (r_col == c_col_last) begin
                                r_col  <= '0;
                                r_line <= r_line + 1'b1;
                            end else begin
                                r_col <= r_col + 1'b1;
                            end
                            r_rclk  <= 1'b0;
                            r_state <= c_rd_entry;
                        end
                    end
                end

`ifdef OV_FIFO_READER_TRAILER_EN
                // CR then LF, each through the normal handshake
                ST_TRAILER: begin
                    if (w_hs) begin
                        if (!r_trl_lf) begin
                            r_m_data <= TRAILER_LF;
                            r_m_last <= 1'b1;
                            r_trl_lf <= 1'b1;
                        end else begin
                            r_m_valid <= 1'b0;
                            r_m_last  <= 1'b0;
                            r_state   <= ST_DONE;
                        end
                    end
                end
`endif

                ST_DONE: begin
                    r_frame_read <= 1'b1;
                    r_state      <= ST_IDLE;
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rclk       = r_rclk;
    assign rrst       = r_rrst;
    assign frame_read = r_frame_read;
    assign m_valid    = r_m_valid;
    assign m_data     = r_m_data;
    assign m_last     = r_m_last;

endmodule

`default_nettype wire

// File: tb/tb_ov_fifo_window_reader.sv
// ============================================================================
//  Module      : tb_ov_fifo_window_reader
//  Description : Self-checking bench for ov_fifo_window_reader with a 4x3x2
//                frame, a 2x1 window at (1,1) and a two-cycle rclk
//                half-period. The FIFO model returns the read-pointer value.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ov_fifo_window_reader;

    localparam int H_RES    = 4;
    localparam int V_RES    = 3;
    localparam int BPP      = 2;
    localparam int X0       = 1;
    localparam int Y0       = 1;
    localparam int WIN_W    = 2;
    localparam int WIN_H    = 1;
    localparam int RCLK_DIV = 2;

    logic       clk_25MHz   = 1'b0;
    logic       rst_n       = 1'b0;
    logic       initialized = 1'b0;
    logic       new_frame   = 1'b0;
    logic       m_ready     = 1'b1;
    logic [7:0] fifo_data;
    logic       rclk;
    logic       rrst;
    logic       frame_read;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_last;

    int checks   = 0;
    int failures = 0;

    logic [8:0] exp_q[$];
    logic [7:0] fifo_ptr = 8'd0;
    int         rd_rise  = 0;
    int         rd_fall  = 0;
    int         rst_rise = 0;

    ov_fifo_window_reader #(
        .H_RES    (H_RES),
        .V_RES    (V_RES),
        .BPP      (BPP),
        .X0       (X0),
        .Y0       (Y0),
        .WIN_W    (WIN_W),
        .WIN_H    (WIN_H),
        .RCLK_DIV (RCLK_DIV)
    ) dut (
        .clk_25MHz   (clk_25MHz),
        .rst_n       (rst_n),
        .initialized (initialized),
        .new_frame   (new_frame),
        .fifo_data   (fifo_data),
        .rclk        (rclk),
        .rrst        (rrst),
        .frame_read  (frame_read),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last)
    );

    always #20 clk_25MHz = ~clk_25MHz;

    // AL422B read side: rrst low on a rising rclk rewinds, otherwise advance
    assign fifo_data = fifo_ptr;
    always @(posedge rclk) fifo_ptr <= (rrst === 1'b0) ? 8'd0 : fifo_ptr + 8'd1;

    always @(posedge rclk) begin
        #1;
        if (rrst === 1'b1) rd_rise++;
        else rst_rise++;
    end

    always @(negedge rclk) begin
        #1;
        if (rrst === 1'b1) rd_fall++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Stream monitor: scoreboard pop on handshake, stability while stalled
    logic [8:0] prev_beat  = 9'h000;
    bit         prev_stall = 1'b0;
    always @(negedge clk_25MHz) begin
        if (prev_stall && m_valid) chk("axi_hold", {23'd0, m_last, m_data}, {23'd0, prev_beat});
        if (m_valid && m_ready) begin
            chk("stream_extra", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) chk("stream_beat", {23'd0, m_last, m_data}, {23'd0, exp_q.pop_front()});
        end
        prev_stall = m_valid && !m_ready;
        prev_beat  = {m_last, m_data};
    end

    task automatic step();
        @(posedge clk_25MHz);
        #1;
    endtask

    // Window bytes of a frame: line Y0, byte columns X0*BPP .. (X0+WIN_W)*BPP-1
    task automatic push_frame();
        for (int ln = 0; ln < V_RES; ln++) begin
            for (int c = 0; c < H_RES * BPP; c++) begin
                if (ln >= Y0 && ln < Y0 + WIN_H && c >= X0 * BPP && c < (X0 + WIN_W) * BPP) begin
`ifdef OV_FIFO_READER_TRAILER_EN
                    exp_q.push_back({1'b0, 8'(ln * H_RES * BPP + c)});
`else
                    exp_q.push_back({(ln == Y0 + WIN_H - 1) && (c == (X0 + WIN_W) * BPP - 1), 8'(ln * H_RES * BPP + c)});
`endif
                end
            end
        end
`ifdef OV_FIFO_READER_TRAILER_EN
        exp_q.push_back({1'b0, 8'h0D});
        exp_q.push_back({1'b1, 8'h0A});
`endif
    endtask

    task automatic clear_counts();
        rd_rise  = 0;
        rd_fall  = 0;
        rst_rise = 0;
    endtask

    task automatic wait_done(input string tag);
        for (int n = 0; n < 2000 && frame_read !== 1'b1; n++) step();
        chk({tag, "_done"}, 32'(frame_read), 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        for (int n = 0; n < 400 && m_valid !== 1'b1; n++) step();
        chk({tag, "_valid"}, 32'(m_valid), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rclk"}, 32'(rclk), 32'd1);
        chk({tag, "_rrst"}, 32'(rrst), 32'd1);
        chk({tag, "_frame_read"}, 32'(frame_read), 32'd1);
        chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        chk({tag, "_m_data"}, 32'(m_data), 32'd0);
        chk({tag, "_m_last"}, 32'(m_last), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) step();
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // new_frame without initialized must not start
        new_frame = 1'b1;
        repeat (20) step();
        chk("uninit_frame_read", 32'(frame_read), 32'd1);
        chk("uninit_rrst", 32'(rrst), 32'd1);
        chk("uninit_rclk", 32'(rclk), 32'd1);

        // Frame 1: starts once initialized rises, mid-frame new_frame ignored
        push_frame();
        clear_counts();
        initialized = 1'b1;
        step();
        chk("f1_start", 32'(frame_read), 32'd0);
        new_frame = 1'b0;
        repeat (60) step();
        new_frame = 1'b1;
        step();
        new_frame = 1'b0;
        wait_done("f1");
        chk("f1_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("f1_ptr_rst_edges", 32'(rst_rise), 32'd2);
        chk("f1_read_falls", 32'(rd_fall), 32'd24);
        chk("f1_read_rises", 32'(rd_rise), 32'd24);
        chk("f1_fifo_ptr", 32'(fifo_ptr), 32'd24);
        repeat (5) step();
        chk("f1_no_restart", 32'(frame_read), 32'd1);

        // Frame 2: stall the second byte for 50 cycles, drop initialized mid-frame
        m_ready = 1'b0;
        push_frame();
        clear_counts();
        new_frame = 1'b1;
        step();
        new_frame = 1'b0;
        wait_valid("f2_b0");
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("f2_valid_drop", 32'(m_valid), 32'd0);
        initialized = 1'b0;
        wait_valid("f2_b1");
        for (int i = 0; i < 50; i++) begin
            step();
            chk("f2_stall_rclk", 32'(rclk), 32'd0);
        end
        chk("f2_stall_valid", 32'(m_valid), 32'd1);
        chk("f2_stall_data", 32'(m_data), 32'h0B);
        m_ready = 1'b1;
        wait_done("f2");
        chk("f2_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("f2_read_falls", 32'(rd_fall), 32'd24);
        initialized = 1'b1;

        // Frame 3: asynchronous reset just as byte 10 reaches the bus
        new_frame = 1'b1;
        step();
        new_frame = 1'b0;
        for (int n = 0; n < 400 && fifo_ptr != 8'd10; n++) step();
        chk("f3_reach_byte10", 32'(fifo_ptr), 32'd10);
        #5;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("f3_idle_after_reset", 32'(frame_read), 32'd1);

        // Frames 4 and 5: new_frame held high restarts right after completion
        push_frame();
        push_frame();
        clear_counts();
        new_frame = 1'b1;
        step();
        chk("f4_start", 32'(frame_read), 32'd0);
        wait_done("f4");
        step();
        chk("f5_restart", 32'(frame_read), 32'd0);
        new_frame = 1'b0;
        wait_done("f5");
        chk("f5_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("f45_read_falls", 32'(rd_fall), 32'd48);
        chk("f45_ptr_rst_edges", 32'(rst_rise), 32'd4);

        repeat (5) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
